// File: rtl/pal_check_seq_if.sv
// pal_check_seq_if: request/result valid-ready bus for pal_check_seq
// master = request source and result consumer, slave = pal_check_seq
interface pal_check_seq_if;
  logic        in_valid, in_ready, mode, out_valid, out_ready, is_palindrome;
  logic [15:0] number;
  modport master (output in_valid, number, mode, out_ready, input in_ready, out_valid, is_palindrome);
  modport slave  (input in_valid, number, mode, out_ready, output in_ready, out_valid, is_palindrome);
endinterface

// File: rtl/pal_check_seq.sv
// pal_check_seq: multi-cycle 16-bit binary / 5-digit decimal palindrome checker
// Ports: clk, rst_n (async active-low), bus (slave: in_valid/in_ready/number/mode in,
// out_valid/out_ready/is_palindrome out). Define PAL_STATS_EN for stat_total/stat_pal.
module pal_check_seq (
  input  logic           clk,
  input  logic           rst_n,
  pal_check_seq_if.slave bus
`ifdef PAL_STATS_EN
  ,
  output logic [15:0]    stat_total,
  output logic [15:0]    stat_pal
`endif
);
  typedef enum logic [2:0] {IDLE, BIN, DIV, CMP, DONE} state_t;
  state_t      r_state;
  logic [15:0] r_q;
  logic [3:0]  r_idx, r_r, r_d0, r_d1, r_d3, r_d4;
  logic [2:0]  r_k;
  logic        r_pal;
  logic [4:0]  w_t;
  logic [3:0]  w_rn, w_mir;
  logic        w_ge, w_mis;
  // remainder never exceeds 9, so t-10 fits in 4 bits modulo 16
  assign w_t   = {r_r, r_q[15]};
  assign w_ge  = w_t >= 5'd10;
  assign w_rn  = w_ge ? w_t[3:0] - 4'd10 : w_t[3:0];
  assign w_mir = 4'd15 - r_idx;
  assign w_mis = r_q[r_idx] != r_q[w_mir];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state           <= IDLE;
      r_q               <= '0;
      r_idx             <= '0;
      r_r               <= '0;
      r_k               <= '0;
      r_pal             <= 1'b0;
      r_d0              <= '0;
      r_d1              <= '0;
      r_d3              <= '0;
      r_d4              <= '0;
      bus.in_ready      <= 1'b1;
      bus.out_valid     <= 1'b0;
      bus.is_palindrome <= 1'b0;
    end else
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_q          <= bus.number;
          r_pal        <= 1'b1;
          r_idx        <= '0;
          r_r          <= '0;
          r_k          <= '0;
          r_state      <= bus.mode ? DIV : BIN;
          bus.in_ready <= 1'b0;
        end
        BIN: begin
          r_pal <= r_pal & ~w_mis;
          r_idx <= r_idx + 4'd1;
          if (r_idx == 4'd7) begin
            r_state           <= DONE;
            bus.out_valid     <= 1'b1;
            bus.is_palindrome <= r_pal & ~w_mis;
          end
        end
        DIV: begin
          // quotient bits shift into q, so q holds the next dividend after 16 steps
          r_q   <= {r_q[14:0], w_ge};
          r_idx <= r_idx + 4'd1;
          r_r   <= r_idx == 4'd15 ? 4'd0 : w_rn;
          if (r_idx == 4'd15) begin
            r_k <= r_k + 3'd1;
            if (r_k == 3'd0) r_d0 <= w_rn;
            if (r_k == 3'd1) r_d1 <= w_rn;
            if (r_k == 3'd3) r_d3 <= w_rn;
            if (r_k == 3'd4) r_d4 <= w_rn;
            if (r_k == 3'd4) r_state <= CMP;
          end
        end
        CMP: begin
          r_pal             <= (r_d0 == r_d4) && (r_d1 == r_d3);
          bus.is_palindrome <= (r_d0 == r_d4) && (r_d1 == r_d3);
          bus.out_valid     <= 1'b1;
          r_state           <= DONE;
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          r_state       <= IDLE;
        end
        default: begin
          r_state       <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
`ifdef PAL_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_total <= '0;
      stat_pal   <= '0;
    end else if (r_state == DONE && bus.out_ready) begin
      stat_total <= stat_total + {15'd0, ~&stat_total};
      stat_pal   <= stat_pal + {15'd0, bus.is_palindrome & ~&stat_pal};
    end
`endif
endmodule

// File: tb/tb_pal_check_seq.sv
// tb_pal_check_seq: scoreboard bench for pal_check_seq with a digit-level reference model
module tb_pal_check_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  int   cyc = 0, n_chk = 0, n_fail = 0, ready_mode = 0;
  typedef struct {logic pal; int acc; int lat;} exp_t;
  exp_t exp_q[$];
  exp_t cur;
  logic prev_ov = 1'b0, prev_hs = 1'b0, held_pal = 1'b0;
  int   m_total = 0, m_pal = 0;
  pal_check_seq_if bus();
`ifdef PAL_STATS_EN
  logic [15:0] stat_total, stat_pal;
  pal_check_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus), .stat_total(stat_total), .stat_pal(stat_pal));
`else
  pal_check_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic ref_pal(input logic [15:0] n, input logic m);
    logic [15:0] rv;
    int v, d[5];
    rv = {<<{n}};
    if (!m) return n == rv;
    v = n;
    for (int i = 0; i < 5; i++) begin d[i] = v % 10; v = v / 10; end
    return d[0] == d[4] && d[1] == d[3];
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic send(input logic [15:0] n, input logic m, input bit hold);
    int b = 0;
    bus.in_valid = 1'b1; bus.number = n; bus.mode = m;
    while (!bus.in_ready && b < 300) begin @(negedge clk); b++; end
    if (!bus.in_ready) begin check("accept_timeout", 0, 1); bus.in_valid = 1'b0; return; end
    exp_q.push_back('{ref_pal(n, m), cyc + 1, m ? 81 : 8});
    @(negedge clk);
    bus.number = 16'($urandom);
    bus.mode = 1'($urandom);
    if (!hold) bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 3000) begin @(negedge clk); b++; end
    if (exp_q.size() != 0) check("drain_timeout", 0, 1);
    @(negedge clk);
  endtask
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom) : 1'b0;
    end
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      check("no_ov_in_reset", bus.out_valid, 0);
      prev_ov = 1'b0; prev_hs = 1'b0;
    end else begin
      if (prev_hs) begin
        check("ov_drop", bus.out_valid, 0);
        check("ready_after_done", bus.in_ready, 1);
      end
      if (bus.out_valid) begin
        check("ready_low_in_done", bus.in_ready, 0);
        if (!prev_ov) begin
          if (exp_q.size() == 0) check("unexpected_ov", 1, 0);
          else begin
            cur = exp_q[0];
            check("latency", cyc - cur.acc, cur.lat);
            check("result", bus.is_palindrome, cur.pal);
            held_pal = bus.is_palindrome;
          end
        end else check("hold_result", bus.is_palindrome, held_pal);
        if (bus.out_ready && exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          if (m_total < 65535) m_total++;
          if (cur.pal && m_pal < 65535) m_pal++;
        end
      end
      prev_hs = bus.out_valid && bus.out_ready;
      prev_ov = bus.out_valid && !bus.out_ready;
    end
  end
  initial begin
    int b;
    logic [15:0] bin_v[3] = '{16'h8001, 16'h8000, 16'hFFFF};
    logic [15:0] dec_v[5] = '{16'd12321, 16'd10001, 16'd121, 16'd0, 16'd65535};
    bus.in_valid = 1'b0; bus.number = '0; bus.mode = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_is_pal", bus.is_palindrome, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    foreach (bin_v[i]) send(bin_v[i], 1'b0, 1'b0);
    foreach (dec_v[i]) send(dec_v[i], 1'b1, 1'b0);
    drain();
    check("model_12321", ref_pal(16'd12321, 1'b1), 1);
    check("model_121", ref_pal(16'd121, 1'b1), 0);
    ready_mode = 2;
    send(16'd4554, 1'b1, 1'b0);
    b = 0;
    while (!bus.out_valid && b < 200) begin @(negedge clk); b++; end
    check("stall_ov_seen", bus.out_valid, 1);
    repeat (20) @(negedge clk);
    check("stall_ov_held", bus.out_valid, 1);
    ready_mode = 0;
    drain();
    send(16'h1008, 1'b0, 1'b1);
    send(16'd23432, 1'b1, 1'b1);
    send(16'hA5A5, 1'b0, 1'b1);
    send(16'd12345, 1'b1, 1'b0);
    drain();
    ready_mode = 1;
    for (int i = 0; i < 40; i++) begin
      send(16'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
    bus.in_valid = 1'b0;
    drain();
    ready_mode = 0;
    send(16'd12321, 1'b1, 1'b0);
    repeat (39) @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete(); m_total = 0; m_pal = 0;
    #1;
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_is_pal", bus.is_palindrome, 0);
`ifdef PAL_STATS_EN
    check("abort_stat_total", stat_total, 0);
    check("abort_stat_pal", stat_pal, 0);
`endif
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    send(16'd10001, 1'b1, 1'b0);
    send(16'h8001, 1'b0, 1'b0);
    send(16'd121, 1'b1, 1'b0);
    send(16'hFFFF, 1'b0, 1'b0);
    send(16'h8000, 1'b0, 1'b0);
    drain();
`ifdef PAL_STATS_EN
    check("stat_total", stat_total, 5);
    check("stat_pal", stat_pal, 3);
    check("stat_total_model", stat_total, m_total);
    force dut.stat_total = 16'hFFFF;
    force dut.stat_pal = 16'hFFFF;
    @(negedge clk);
    release dut.stat_total;
    release dut.stat_pal;
    m_total = 65535; m_pal = 65535;
    send(16'd12321, 1'b1, 1'b0);
    drain();
    check("stat_total_sat", stat_total, 16'hFFFF);
    check("stat_pal_sat", stat_pal, 16'hFFFF);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
